delay_line_ctrl: RTL

//  Circular-buffer delay line in the board's external async SRAM, feeding delay-based effects (chorus, echo).

---
 rtl/delay_line_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/delay_line_ctrl.sv
// Circular-buffer delay line held in external async SRAM: stores each incoming sample,
// then serves tap reads at a sample offset back from the newest stored sample.
module delay_line_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int BUF_AW     = 12,
    parameter int SRAM_AW    = 18,
    parameter int BASE_ADDR  = 0,
    parameter int WAIT_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] offset,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  read_finish,
    output logic                  busy,
    output logic                  overrun,
    output logic [SRAM_AW-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);

    localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int DW = (ADDR_WIDTH - 1 > BUF_AW) ? ADDR_WIDTH - 1 : BUF_AW;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_DONE} state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [BUF_AW-1:0]     wr_ptr_reg;
    logic                  wr_pend_reg;
    logic [DATA_WIDTH-1:0] wr_sample_reg;
    logic                  rd_pend_reg;
    logic [BUF_AW-1:0]     rd_dist_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  read_finish_reg;
    logic                  overrun_reg;
    logic [SRAM_AW-1:0]    sram_addr_reg;
    logic [DATA_WIDTH-1:0] sram_wdata_reg;
    logic                  dq_oe_reg, ce_n_reg, oe_n_reg, we_n_reg;

    logic                  cnt_last;
    logic                  start_wr, start_rd;
    logic                  wr_done, rd_capture, rd_clear;
    logic [BUF_AW-1:0]     rd_index;
    logic [DW-1:0]         dist_wide;
    logic                  unused_lsb;

    // Byte offset to word distance; anything above the buffer depth wraps away.
    assign dist_wide  = DW'(offset[ADDR_WIDTH-1:1]);
    assign unused_lsb = offset[0];
    generate
        if (DW > BUF_AW) begin : g_trim
            logic unused_hi;
            assign unused_hi = ^dist_wide[DW-1:BUF_AW];
        end
    endgenerate

    assign cnt_last = (cnt_reg == CW'(WAIT_CYC - 1));
    assign start_wr = (state_reg == IDLE) && wr_pend_reg;
    assign start_rd = (state_reg == IDLE) && !wr_pend_reg && rd_pend_reg;
    // Index uses wr_ptr at issue time, so a write that won arbitration is visible.
    assign rd_index = wr_ptr_reg - BUF_AW'(1) - rd_dist_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_done    = 1'b0;
        rd_capture = 1'b0;
        rd_clear   = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (wr_pend_reg)      state_next = WR;
                else if (rd_pend_reg) state_next = RD;
            end
            WR: begin
                if (cnt_last) begin
                    wr_done    = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RD: begin
                if (cnt_last) begin
                    rd_capture = 1'b1;
                    cnt_next   = '0;
                    state_next = RD_DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RD_DONE: begin
                rd_clear   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            wr_ptr_reg      <= '0;
            wr_pend_reg     <= 1'b0;
            wr_sample_reg   <= '0;
            rd_pend_reg     <= 1'b0;
            rd_dist_reg     <= '0;
            rd_data_reg     <= '0;
            read_finish_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            sram_addr_reg   <= '0;
            sram_wdata_reg  <= '0;
            dq_oe_reg       <= 1'b0;
            ce_n_reg        <= 1'b1;
            oe_n_reg        <= 1'b1;
            we_n_reg        <= 1'b1;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            read_finish_reg <= rd_clear;

            if (rd_capture) rd_data_reg <= sram_rdata;
            if (wr_done)    wr_ptr_reg  <= wr_ptr_reg + BUF_AW'(1);

            // A full slot drops the new request, even on the cycle it is being consumed.
            if (wr_done) wr_pend_reg <= 1'b0;
            if (sample_valid && !wr_pend_reg) begin
                wr_pend_reg   <= 1'b1;
                wr_sample_reg <= sample_in;
            end
            if (rd_clear) rd_pend_reg <= 1'b0;
            if (rd && !rd_pend_reg) begin
                rd_pend_reg <= 1'b1;
                rd_dist_reg <= dist_wide[BUF_AW-1:0];
            end
            if ((sample_valid && wr_pend_reg) || (rd && rd_pend_reg))
                overrun_reg <= 1'b1;

            // SRAM pins are registered and track the state register edge for edge.
            if (start_wr) begin
                sram_addr_reg  <= SRAM_AW'(BASE_ADDR) + SRAM_AW'(wr_ptr_reg);
                sram_wdata_reg <= wr_sample_reg;
                dq_oe_reg      <= 1'b1;
                ce_n_reg       <= 1'b0;
                we_n_reg       <= 1'b0;
            end else if (start_rd) begin
                sram_addr_reg <= SRAM_AW'(BASE_ADDR) + SRAM_AW'(rd_index);
                ce_n_reg      <= 1'b0;
                oe_n_reg      <= 1'b0;
            end else if (wr_done || rd_capture) begin
                dq_oe_reg <= 1'b0;
                ce_n_reg  <= 1'b1;
                oe_n_reg  <= 1'b1;
                we_n_reg  <= 1'b1;
            end
        end
    end

    assign rd_data     = rd_data_reg;
    assign read_finish = read_finish_reg;
    assign busy        = (state_reg != IDLE) || wr_pend_reg || rd_pend_reg;
    assign overrun     = overrun_reg;
    assign sram_addr   = sram_addr_reg;
    assign sram_wdata  = sram_wdata_reg;
    assign sram_dq_oe  = dq_oe_reg;
    assign sram_ce_n   = ce_n_reg;
    assign sram_oe_n   = oe_n_reg;
    assign sram_we_n   = we_n_reg;

endmodule
